// File: rtl/alu_seq_div.sv
// alu_seq_div: multicycle unsigned divider (restoring shift-and-subtract).
// One quotient bit is resolved per clock while busy; results are presented
// with a one-cycle done pulse and held until the next accepted start.
// Divide by zero skips iteration and returns all-ones / dividend with a flag.

module alu_seq_div #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] dvsr_q;
   logic [WIDTH-1:0] q_q;
   // Settled partial remainder. After each restoring step it is strictly
   // below the divisor, so its top bit (bit WIDTH of the WIDTH+1-bit R) is
   // always zero and only the low WIDTH bits are stored.
   logic [WIDTH-1:0] r_q;

   logic [WIDTH:0]   r_shift;
   logic [WIDTH:0]   r_trial;
   logic [WIDTH-1:0] q_step;
   logic [WIDTH-1:0] r_step;

   // One restoring step: shift {R,Q} left, trial-subtract the divisor,
   // keep the difference and set the quotient bit when it did not borrow.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      q_step  = {q_q[WIDTH-2:0], 1'b0};
      r_shift = {r_q, q_q[WIDTH-1]};
      r_trial = r_shift - {1'b0, dvsr_q};
      r_step  = r_shift[WIDTH-1:0];
      if (!r_trial[WIDTH]) begin
         r_step    = r_trial[WIDTH-1:0];
         q_step[0] = 1'b1;
      end
   end

   // Control FSM, datapath registers and held result registers.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         dvsr_q      <= '0;
         q_q         <= '0;
         r_q         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  if (divisor != '0) begin
                     dvsr_q      <= divisor;
                     q_q         <= dividend;
                     r_q         <= '0;
                     cnt_q       <= '0;
                     div_by_zero <= 1'b0;
                     state_q     <= S_RUN;
                  end else begin
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                     state_q     <= S_DONE;
                  end
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_RUN: begin
               q_q   <= q_step;
               r_q   <= r_step;
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == LAST_STEP) begin
                  quotient  <= q_step;
                  remainder <= r_step;
                  state_q   <= S_DONE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Status outputs decode the state register only; no input reaches them.
   always_comb begin
      busy = (state_q == S_RUN);
      done = (state_q == S_DONE);
   end

endmodule

// File: tb/tb_alu_seq_div.sv
// tb_alu_seq_div: randomized and directed checks of alu_seq_div (WIDTH=8)
// against a plain-arithmetic reference using / and %, including latency,
// busy duration, ignored starts, back-to-back issue and mid-run reset.

module tb_alu_seq_div;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int checks = 0;
   int errors = 0;

   alu_seq_div #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request for exactly one edge, then scramble the operands.
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      tick();
      start    = 1'b0;
      dividend = W'($urandom);
      divisor  = W'($urandom);
   endtask

   // Called right after the accepting edge. Follows the operation to its
   // done pulse (bounded), optionally pulsing a start while running, and
   // compares latency, busy length and results to the reference.
   task automatic wait_result(input string tag, input logic [W-1:0] a,
                              input logic [W-1:0] b, input int pulse_at);
      int           lat;
      int           bcnt;
      bit           ovl;
      logic [W-1:0] eq;
      logic [W-1:0] er;
      lat  = 0;
      bcnt = 0;
      ovl  = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         if (busy) bcnt++;
         if (busy && done) ovl = 1'b1;
         if (done) begin
            lat = n;
            break;
         end
         if (n == pulse_at) begin
            start    = 1'b1;
            dividend = 8'd9;
            divisor  = 8'd2;
         end
         tick();
         start = 1'b0;
      end
      if (b == 0) begin
         eq = '1;
         er = a;
      end else begin
         eq = a / b;
         er = a % b;
      end
      check({tag, " latency"},   lat,  (b == 0) ? 1 : W + 1);
      check({tag, " busy_len"},  bcnt, (b == 0) ? 0 : W);
      check({tag, " overlap"},   ovl,  0);
      check({tag, " quotient"},  quotient,  eq);
      check({tag, " remainder"}, remainder, er);
      check({tag, " dbz"},       div_by_zero, (b == 0));
   endtask

   task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
      start_op(a, b);
      wait_result(tag, a, b, 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " busy"},      busy, 0);
      check({tag, " done"},      done, 0);
      check({tag, " quotient"},  quotient, 0);
      check({tag, " remainder"}, remainder, 0);
      check({tag, " dbz"},       div_by_zero, 0);
   endtask

   logic [W-1:0] ra;
   logic [W-1:0] rb;
   int           dcnt;

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      tick();
      start = 1'b1;        // start during reset must be dropped
      tick();
      start = 1'b0;
      check_all_zero("reset");
      rst = 1'b0;
      tick();
      check("idle done", done, 0);

      // Basic operation and held result.
      run_div("100/7", 8'd100, 8'd7);
      tick();
      check("post done", done, 0);
      check("post busy", busy, 0);
      check("held quotient", quotient, 14);
      check("held remainder", remainder, 2);

      run_div("255/1", 8'd255, 8'd1);
      run_div("5/9", 8'd5, 8'd9);
      run_div("255/255", 8'd255, 8'd255);

      // Divide by zero, then a normal op clears the flag.
      tick();
      run_div("37/0", 8'd37, 8'd0);
      run_div("10/3", 8'd10, 8'd3);
      tick();

      // Start ignored mid-run, then start held through DONE.
      start_op(8'd200, 8'd13);
      wait_result("200/13", 8'd200, 8'd13, 4);
      start_op(8'd50, 8'd6);
      check("b2b busy", busy, 1);
      wait_result("50/6", 8'd50, 8'd6, 0);
      tick();

      // Reset in RUN cycle 3 aborts with no done pulse.
      start_op(8'd100, 8'd7);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_all_zero("mid reset");
      dcnt = 0;
      for (int n = 0; n < 12; n++) begin
         if (done) dcnt++;
         tick();
      end
      check("mid reset no done", dcnt, 0);
      run_div("9/4", 8'd9, 8'd4);

      // Random sweep with forced edge values, random idle gaps and
      // random ignored starts during RUN.
      for (int i = 0; i < 2000; i++) begin
         case ($urandom_range(0, 5))
            0: ra = 8'd0;
            1: ra = 8'd255;
            default: ra = W'($urandom);
         endcase
         case ($urandom_range(0, 5))
            0: rb = 8'd0;
            1: rb = 8'd255;
            default: rb = W'($urandom);
         endcase
         if ($urandom_range(0, 1) == 1) tick();
         start_op(ra, rb);
         if (rb != 0 && $urandom_range(0, 3) == 0)
            wait_result("rand", ra, rb, $urandom_range(1, W));
         else
            wait_result("rand", ra, rb, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
